// File: rtl/cfg_access_pkg.sv
// Shared state encodings and width helpers for the configuration access controller.
package cfg_access_pkg;

    // Raw 3-bit state encodings as seen on o_dbg_state
    localparam logic [2:0] ENC_IDLE    = 3'b001;
    localparam logic [2:0] ENC_ACTIVE  = 3'b010;
    localparam logic [2:0] ENC_REQUEST = 3'b011;
    localparam logic [2:0] ENC_STORE   = 3'b100;
    localparam logic [2:0] ENC_TRAP    = 3'b101;
    localparam logic [2:0] ENC_LOCK    = 3'b110;

    typedef enum logic [2:0] {
        StIdle    = ENC_IDLE,
        StActive  = ENC_ACTIVE,
        StRequest = ENC_REQUEST,
        StStore   = ENC_STORE,
        StTrap    = ENC_TRAP,
        StLock    = ENC_LOCK
    } state_e;

    // Bits needed to index n values, never less than one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals arriving asynchronously to i_clk.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter chain with synchronous clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/cfg_access_ctrl.sv
// Password-gated configuration write controller: authenticates the user against the
// system key, then issues a single write pulse carrying the latched word and slot.
module cfg_access_ctrl
    import cfg_access_pkg::*;
#(
    parameter int unsigned CFG_W       = 35,
    parameter int unsigned PASS_W      = 2,
    parameter int unsigned NUM_SLOTS   = 4,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned LOCK_CYCLES = 1023,
    localparam int unsigned SLOT_W     = cnt_width(NUM_SLOTS),
    localparam int unsigned FAIL_W     = cnt_width(MAX_TRIES + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_request,
    input  logic              i_confirm,
    input  logic [PASS_W-1:0] i_password,
    input  logic [PASS_W-1:0] i_syskey,
    input  logic [SLOT_W-1:0] i_slot_in,
    input  logic [CFG_W-1:0]  i_configin,
    output logic [CFG_W-1:0]  o_configout,
    output logic [SLOT_W-1:0] o_slot_out,
    output logic              o_write_en,
    output logic [FAIL_W-1:0] o_fail_cnt,
    output logic              o_locked,
    output logic [2:0]        o_dbg_state
);

    localparam int unsigned TMR_W = cnt_width(TIMEOUT + 1);
    localparam int unsigned LCK_W = cnt_width(LOCK_CYCLES + 1);
    // TIMEOUT == 0 wraps here, but w_timeout is gated off in that case
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCK_CYCLES - 1);

    state_e            r_state, w_state_d;
    logic              r_confirm_q;
    logic              w_req_s, w_conf_p;
    logic [TMR_W-1:0]  r_tmr, w_tmr_d;
    logic [LCK_W-1:0]  r_lck, w_lck_d;
    logic [FAIL_W-1:0] r_fail, w_fail_d, w_fail_inc;
    logic [CFG_W-1:0]  r_cfg, w_cfg_d;
    logic [SLOT_W-1:0] r_slot, w_slot_d;
    logic              r_we, r_locked;
    logic              w_pass_ok, w_slot_ok, w_timeout;

    sync_2ff #(
        .WIDTH (1)
    ) u_req_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_request),
        .o_q     (w_req_s)
    );

    assign w_conf_p   = i_confirm & ~r_confirm_q;
    assign w_pass_ok  = (i_password == i_syskey);
    assign w_slot_ok  = (32'(i_slot_in) < NUM_SLOTS);
    assign w_timeout  = (TIMEOUT != 0) && (r_tmr == TMR_LAST);
    assign w_fail_inc = r_fail + 1'b1;

    // Next-state, timer and latched-data decode; request loss beats confirm beats timeout
    always_comb begin
        w_state_d = r_state;
        w_tmr_d   = '0;
        w_lck_d   = '0;
        w_fail_d  = r_fail;
        w_cfg_d   = r_cfg;
        w_slot_d  = r_slot;
        case (r_state)
            StIdle: begin
                if (w_req_s) w_state_d = StActive;
            end
            StActive: begin
                if (!w_req_s) begin
                    w_state_d = StIdle;
                end else if (w_conf_p) begin
                    if (w_pass_ok) begin
                        w_state_d = StRequest;
                        w_fail_d  = '0;
                    end else begin
                        w_fail_d = w_fail_inc;
                        if (w_fail_inc == FAIL_W'(MAX_TRIES)) begin
                            w_state_d = StLock;
                            w_lck_d   = LCK_LOAD;
                        end else begin
                            w_state_d = StTrap;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end else begin
                    w_tmr_d = r_tmr + 1'b1;
                end
            end
            StRequest: begin
                if (!w_req_s) begin
                    w_state_d = StIdle;
                end else if (w_conf_p) begin
                    if (w_slot_ok) begin
                        w_state_d = StStore;
                        w_cfg_d   = i_configin;
                        w_slot_d  = i_slot_in;
                    end else begin
                        w_state_d = StTrap;
                    end
                end else if (w_timeout) begin
                    w_state_d = StIdle;
                end else begin
                    w_tmr_d = r_tmr + 1'b1;
                end
            end
            StStore: begin
                w_state_d = StIdle;
            end
            StTrap: begin
                if (!w_req_s) w_state_d = StIdle;
            end
            StLock: begin
                if (r_lck == '0) begin
                    w_state_d = StIdle;
                    w_fail_d  = '0;
                end else begin
                    w_lck_d = r_lck - 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State, timers and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_confirm_q <= 1'b0;
            r_tmr       <= '0;
            r_lck       <= '0;
            r_fail      <= '0;
            r_cfg       <= '0;
            r_slot      <= '0;
            r_we        <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_confirm_q <= i_confirm;
            r_tmr       <= w_tmr_d;
            r_lck       <= w_lck_d;
            r_fail      <= w_fail_d;
            r_cfg       <= w_cfg_d;
            r_slot      <= w_slot_d;
            r_we        <= (w_state_d == StStore);
            r_locked    <= (w_state_d == StLock);
        end
    end

    assign o_configout = r_cfg;
    assign o_slot_out  = r_slot;
    assign o_write_en  = r_we;
    assign o_fail_cnt  = r_fail;
    assign o_locked    = r_locked;
    assign o_dbg_state = r_state;

endmodule
